det_sequencer: RTL



---
 rtl/det_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/det_sequencer.sv
// det_sequencer: captures a 3x3 signed matrix on start and evaluates its
// determinant by Sarrus' rule on one shared signed multiplier. Each of the six
// triple products takes two cycles (MUL1: x*y, MUL2: p*z plus accumulate).
// Optional feature macro: DET_2X2_EN adds the mode input (1 = 2x2 determinant).
module det_sequencer #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [9*DW-1:0] mat,
`ifdef DET_2X2_EN
  input  logic            mode,
`endif
  output logic            busy,
  output logic            done,
  output logic [31:0]     det,
  output logic            res_sel
);

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, DONE} state_t;

  state_t                   state, state_n;
  logic                     accept;
  logic                     last;
  logic [2:0]               k, k_inc;
  logic [9*DW-1:0]          mat_r;
  logic signed [DW-1:0]     m [9];
  logic signed [DW-1:0]     x, y, z;
  logic                     neg;
  logic signed [2*DW-1:0]   p;
  logic signed [2*DW-1:0]   mul_a;
  logic signed [DW-1:0]     mul_b;
  logic signed [3*DW-1:0]   prod;
  logic signed [31:0]       term, acc, acc_next;
  logic                     two_by_two;

`ifdef DET_2X2_EN
  logic mode_r;
  assign two_by_two = mode_r;
`else
  assign two_by_two = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; start is only honoured in IDLE and DONE.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latches).
    state_n = state;
    accept  = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_n = MUL1;
          accept  = 1'b1;
        end else begin
          state_n = IDLE;
        end
      end
      MUL1:    state_n = MUL2;
      MUL2:    state_n = last ? DONE : MUL1;
      default: state_n = IDLE;
    endcase
  end

  // Unpack the captured matrix into row-major elements m0..m8.
  always_comb begin
    for (int i = 0; i < 9; i++) m[i] = mat_r[i*DW +: DW];
  end

  // Term table: operands and sign of the k-th Sarrus product.
  always_comb begin
    x   = '0;
    y   = '0;
    z   = '0;
    neg = 1'b0;
    case (k)
      3'd0: begin x = m[0]; y = m[4]; z = m[8]; end
      3'd1: begin x = m[1]; y = m[5]; z = m[6]; end
      3'd2: begin x = m[2]; y = m[3]; z = m[7]; end
      3'd3: begin x = m[2]; y = m[4]; z = m[6]; neg = 1'b1; end
      3'd4: begin x = m[1]; y = m[3]; z = m[8]; neg = 1'b1; end
      3'd5: begin x = m[0]; y = m[5]; z = m[7]; neg = 1'b1; end
      default: ;
    endcase
    // 2x2 mode: only terms 0 and 5' run, and the third factor is forced to 1.
    if (two_by_two) begin
      z = DW'(1);
      if (k == 3'd5) begin
        x = m[1];
        y = m[3];
      end
    end
  end

  // Shared multiplier: x*y in MUL1, p*z in MUL2; sign-extended operands.
  assign mul_a    = (state == MUL1) ? (2*DW)'(x) : p;
  assign mul_b    = (state == MUL1) ? y : z;
  assign prod     = (3*DW)'(mul_a) * (3*DW)'(mul_b);
  assign term     = 32'(prod);
  assign acc_next = neg ? (acc - term) : (acc + term);
  assign last     = (k == 3'd5);
  assign k_inc    = two_by_two ? 3'd5 : (k + 3'd1);

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data-only registers (mat_r, p) are reset too; they are few
      // and it keeps X out of the multiplier in simulation.
      mat_r   <= '0;
      p       <= '0;
      k       <= '0;
      acc     <= '0;
      det     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      res_sel <= 1'b1;
`ifdef DET_2X2_EN
      mode_r  <= 1'b0;
`endif
    end else begin
      busy <= (state_n == MUL1) || (state_n == MUL2);
      done <= (state_n == DONE);
      if (accept) begin
        mat_r   <= mat;
        acc     <= '0;
        k       <= '0;
        res_sel <= 1'b1;
`ifdef DET_2X2_EN
        mode_r  <= mode;
`endif
      end else if (state == MUL1) begin
        p <= prod[2*DW-1:0];
      end else if (state == MUL2) begin
        acc <= acc_next;
        if (last) begin
          // Final term: publish the result in the same edge that enters DONE.
          det     <= acc_next;
          res_sel <= 1'b0;
        end else begin
          k <= k_inc;
        end
      end
    end
  end

endmodule
